// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake: per-source requests and owner release in,
// one-hot grant with encoded select and status out.
interface bus_arbiter_if;
    localparam int unsigned N_SRC = 24;
    localparam int unsigned SEL_W = 5;

    logic [N_SRC-1:0] req;
    logic             bus_release;
    logic [N_SRC-1:0] grant;
    logic [SEL_W-1:0] bus_sel;
    logic             busy;
    logic             timeout;

    modport master (
        output req, bus_release,
        input  grant, bus_sel, busy, timeout
    );

    modport slave (
        input  req, bus_release,
        output grant, bus_sel, busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for a 24-source shared bus with a hold-time limit
// and a one-cycle turnaround gap between owners.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic         clock,
    input  logic         clear,
    bus_arbiter_if.slave bus
);
    localparam int unsigned N_SRC = 24;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;

    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W:0]   cand;
    logic             owner_req;
    logic             rel_any;
    logic             hold_hit;

    assign owner_req = |(grant_q & bus.req);
    assign rel_any   = bus.bus_release || !owner_req;
    assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

    // First set request at or above ptr, wrapping 23 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            cand = (SEL_W+1)'(ptr_q) + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(N_SRC)) begin
                cand = cand - (SEL_W+1)'(N_SRC);
            end
            if (!win_found && bus.req[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = OWN;
            OWN:     if (rel_any || hold_hit) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_d = N_SRC'(1) << win_idx;
                    sel_d   = win_idx + SEL_W'(1);
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    ptr_d   = (win_idx == SEL_W'(N_SRC - 1)) ? '0 : win_idx + SEL_W'(1);
                end
            end
            OWN: begin
                if (rel_any || hold_hit) begin
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    to_d    = hold_hit && !rel_any;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.bus_sel = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a driver pushes reference-model
// expectations per clock, a monitor pops and compares after each rising edge.
module tb_bus_arbiter;
    localparam int unsigned MH = 15;

    logic clock = 1'b0;
    logic clear;

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(MH)) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] grant;
        logic [4:0]  sel;
        logic        busy;
        logic        timeout;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // Reference model: who owns the bus, whether we are in the gap, how long held.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_hold  = 0;
    int m_ptr   = 0;

    function automatic int pick(input logic [23:0] r, input int p);
        for (int i = 0; i < 24; i++) begin
            if (r[(p + i) % 24]) return (p + i) % 24;
        end
        return -1;
    endfunction

    function automatic int sel_of(input logic [23:0] g);
        for (int i = 0; i < 24; i++) begin
            if (g[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic step(input logic [23:0] r, input logic rel);
        exp_t e;
        bit   to;
        bit   done;
        bit   lim;
        int   w;
        @(negedge clock);
        bus.req         = r;
        bus.bus_release = rel;
        to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
                m_ptr   = (w + 1) % 24;
            end
        end else begin
            done = rel || !r[m_owner];
            lim  = (MH != 0) && (m_hold == int'(MH));
            if (done || lim) begin
                to      = lim && !done;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_hold++;
            end
        end
        e.grant   = (m_owner >= 0) ? (24'(1) << m_owner) : 24'(0);
        e.sel     = (m_owner >= 0) ? 5'(m_owner + 1) : 5'(0);
        e.busy    = (m_owner >= 0);
        e.timeout = to;
        e.id      = step_no;
        step_no++;
        sb.push_back(e);
        @(posedge clock);
    endtask

    // Async clear between edges: outputs must drop at once, no gap cycle.
    task automatic do_reset(input string name);
        @(negedge clock);
        #2;
        clear           = 1'b0;
        bus.req         = '0;
        bus.bus_release = 1'b0;
        #1;
        n_tests++;
        if (bus.grant !== 24'(0) || bus.bus_sel !== 5'(0) || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got grant=%h sel=%0d busy=%b timeout=%b, want all zero",
                     name, bus.grant, bus.bus_sel, bus.busy, bus.timeout);
        end
        m_owner = -1;
        m_gap   = 1'b0;
        m_hold  = 0;
        m_ptr   = 0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (bus.grant !== mon_e.grant || bus.bus_sel !== mon_e.sel ||
                bus.busy !== mon_e.busy || bus.timeout !== mon_e.timeout) begin
                n_fail++;
                $display("FAIL step%0d outputs: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
                         mon_e.id, bus.grant, bus.bus_sel, bus.busy, bus.timeout,
                         mon_e.grant, mon_e.sel, mon_e.busy, mon_e.timeout);
            end
        end
        n_tests++;
        if (!$onehot0(bus.grant) || int'(bus.bus_sel) != sel_of(bus.grant)) begin
            n_fail++;
            $display("FAIL grant_encoding: got grant=%h sel=%0d, want one-hot-or-zero grant with matching sel",
                     bus.grant, bus.bus_sel);
        end
    end

    logic [23:0] rr;
    int          relmod;

    initial begin
        clear           = 1'b0;
        bus.req         = '0;
        bus.bus_release = 1'b0;
        #1;
        n_tests++;
        if (bus.grant !== 24'(0) || bus.bus_sel !== 5'(0) || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got grant=%h sel=%0d busy=%b timeout=%b, want all zero",
                     bus.grant, bus.bus_sel, bus.busy, bus.timeout);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Single requester R5.
        step(24'h000020, 1'b0);
        step(24'h000020, 1'b1);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b1);
        do_reset("reset_after_r5");

        // R3 and PC from ptr 0, then PC after the gap.
        step(24'h100008, 1'b0);
        step(24'h100008, 1'b1);
        step(24'h100000, 1'b0);
        step(24'h100000, 1'b0);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b0);
        do_reset("reset_after_pc");

        // Move ptr to 23 via InPort, then C wins and ptr wraps to R0.
        step(24'h400000, 1'b0);
        step(24'h400000, 1'b1);
        step(24'h000000, 1'b0);
        step(24'h800001, 1'b0);
        step(24'h800001, 1'b1);
        step(24'h000001, 1'b0);
        step(24'h000001, 1'b0);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b0);
        do_reset("reset_after_wrap");

        // R2 never releases: forced revoke, then MDR, then R2 again.
        step(24'h000004, 1'b0);
        repeat (20) step(24'h200004, 1'b0);
        step(24'h200004, 1'b1);
        step(24'h000004, 1'b0);
        step(24'h000004, 1'b0);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b0);
        do_reset("reset_after_timeout");

        // Release on the same edge the hold limit is reached.
        step(24'h000004, 1'b0);
        repeat (14) step(24'h000004, 1'b0);
        step(24'h000004, 1'b1);
        step(24'h000000, 1'b0);

        // Clear mid-ownership, then arbitration restarts from ptr 0.
        step(24'h000080, 1'b0);
        step(24'h000080, 1'b0);
        do_reset("clear_mid_own");
        step(24'h000202, 1'b0);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b0);

        // Random traffic with sticky owners and varying release rates.
        for (int it = 0; it < 3000; it++) begin
            relmod = ((it / 500) % 2 == 0) ? 4 : 40;
            if ($urandom_range(199) == 0) begin
                do_reset("random_clear");
            end else begin
                rr = 24'($urandom & $urandom & $urandom);
                if (m_owner >= 0 && $urandom_range(15) != 0) rr[m_owner] = 1'b1;
                step(rr, ($urandom % relmod) == 0);
            end
        end

        step(24'h000000, 1'b1);
        step(24'h000000, 1'b0);
        step(24'h000000, 1'b0);
        @(negedge clock);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
